pipe_skid_reg: RTL

- Generic, parametrised pipeline interstage register with a valid/ready handshake and a 2-entry skid buffer.
- Replaces fixed per-stage registers driven by wr_en/gen_bubble: per-stage data is packed into one WIDTH-bit vector, and a stage stalls through backpressure instead of an external wr_en.
- in_ready is a registered signal, which breaks the combinational ready path between stages; the block also provides a synchronous flush for branch/jump squash.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_skid_reg.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions.
//   pipe_occ_t      : occupancy/state encoding of the interstage skid register
//                     (EMPTY = 0, ONE = 1, FULL = 2); the numeric value is
//                     exported directly as the occupancy count.
//   PIPE_SKID_DEPTH : number of entries an interstage register can hold.
package pipe_pkg;

   typedef enum logic [1:0] {
      PIPE_EMPTY = 2'd0,
      PIPE_ONE   = 2'd1,
      PIPE_FULL  = 2'd2
   } pipe_occ_t;

   localparam int PIPE_SKID_DEPTH = 2;

endpackage : pipe_pkg

// File: rtl/pipe_skid_reg.sv
// Pipeline interstage register with valid/ready handshake and a 2-entry skid
// buffer. Sits between two pipeline stages; the stage payload is packed into
// one WIDTH-bit vector by the surrounding stage wrapper.
//
// Ports
//   clk        in   clock, all logic on posedge
//   reset      in   synchronous active-high reset (highest priority)
//   flush      in   synchronous squash of all held entries (second priority)
//   in_valid   in   upstream offers in_data
//   in_ready   out  registered; 1 = an entry is free this cycle
//   in_data    in   upstream payload
//   out_valid  out  out_data holds a valid op (0 = bubble)
//   out_ready  in   downstream consumes out_data this cycle
//   out_data   out  payload to the next stage (straight from the main register)
//   occupancy  out  entries held: 0, 1 or 2
//
// Parameters
//   WIDTH       payload width in bits (>= 1)
//   BUBBLE_ZERO 1: payload registers clear on reset/flush/drain so out_data
//                  reads 0 whenever out_valid = 0
//               0: payload registers are never cleared (out_data don't-care
//                  while out_valid = 0)
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH       = 64,
   parameter bit BUBBLE_ZERO = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   pipe_occ_t        state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic [WIDTH-1:0] main_q, main_d;   // oldest entry, drives out_data
   logic [WIDTH-1:0] skid_q, skid_d;   // overflow entry, always younger than main

   logic in_fire;
   logic out_fire;

   assign out_valid = (state_q != PIPE_EMPTY);
   assign out_data  = main_q;
   assign occupancy = state_q;
   assign in_ready  = in_ready_q;

   // in_ready_q is 0 only in FULL, so an offer while FULL is simply ignored.
   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      if (flush) begin
         // Any in_fire this cycle is dropped; an out_fire is treated as
         // consumed and the downstream stage squashes it itself.
         state_d = PIPE_EMPTY;
         if (BUBBLE_ZERO) begin
            main_d = '0;
            skid_d = '0;
         end
      end else begin
         case (state_q)
            PIPE_EMPTY: begin
               if (in_fire) begin
                  main_d  = in_data;
                  state_d = PIPE_ONE;
               end
            end
            PIPE_ONE: begin
               if (in_fire && out_fire) begin
                  // full-throughput pass: replace the consumed entry
                  main_d = in_data;
               end else if (in_fire) begin
                  skid_d  = in_data;
                  state_d = PIPE_FULL;
               end else if (out_fire) begin
                  state_d = PIPE_EMPTY;
                  if (BUBBLE_ZERO) begin
                     main_d = '0;
                  end
               end
            end
            PIPE_FULL: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  state_d = PIPE_ONE;
                  if (BUBBLE_ZERO) begin
                     skid_d = '0;
                  end
               end
            end
            default: begin
               state_d = PIPE_EMPTY;
            end
         endcase
      end

      // Registered ready: derived from the next state only, so there is no
      // combinational path from in_* or out_ready to in_ready.
      in_ready_d = (state_d != PIPE_FULL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= PIPE_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
      end
   end

   // Payload registers: cleared on reset only when bubbles must read as zero;
   // otherwise they carry no reset at all.
   always_ff @(posedge clk) begin
      if (reset && BUBBLE_ZERO) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
      end
   end

endmodule : pipe_skid_reg
